// File: rtl/uart_tx_sequencer.sv
// UART transmit frame sequencer: start bit, 8 data bits LSB-first, parity, then 1 or 2 stop bits.
// The byte and its frame configuration are shadowed on accept, so CSR edits only reach later frames.
module uart_tx_sequencer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic       two_stop,
    input  logic       odd_parity,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_line,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;

    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        logic p;
        p = ^data;
        if (odd) begin
            p = ~p;
        end else begin
            p = p;
        end
        return p;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shadow_q, shadow_d;
    logic             two_stop_q, two_stop_d;
    logic             odd_q, odd_d;
    logic             tx_line_q, tx_line_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tx_ready_s;
    logic             accept_s;
    logic             bit_end_s;

    assign tx_ready_s = (state_q == ST_IDLE) && tx_en;
    assign accept_s   = tx_valid && tx_ready_s;
    assign bit_end_s  = (cnt_q == CNT_MAX);

    // Frame state machine: the baud counter restarts on every state entry.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shadow_d   = shadow_q;
        two_stop_d = two_stop_q;
        odd_d      = odd_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (accept_s) begin
                    state_d    = ST_START;
                    bit_idx_d  = 3'd0;
                    shadow_d   = tx_data;
                    two_stop_d = two_stop;
                    odd_d      = odd_parity;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d = ST_DATA;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_d     = CNT_ZERO;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d = ST_STOP1;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP1: begin
                if (bit_end_s) begin
                    cnt_d = CNT_ZERO;
                    if (two_stop_q) begin
                        state_d = ST_STOP2;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP2: begin
                if (bit_end_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = CNT_ZERO;
                bit_idx_d = 3'd0;
            end
        endcase
    end

    // Line level is decoded from the next state so the registered pin lines up with the state.
    always_comb begin
        tx_line_d = 1'b1;
        busy_d    = (state_d != ST_IDLE);
        case (state_d)
            ST_IDLE:   tx_line_d = 1'b1;
            ST_START:  tx_line_d = 1'b0;
            ST_DATA:   tx_line_d = shadow_d[bit_idx_d];
            ST_PARITY: tx_line_d = parity_bit(shadow_d, odd_d);
            ST_STOP1:  tx_line_d = 1'b1;
            ST_STOP2:  tx_line_d = 1'b1;
            default:   tx_line_d = 1'b1;
        endcase
    end

    // State and output registers with synchronous reset; a partial frame is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            bit_idx_q  <= 3'd0;
            shadow_q   <= 8'h00;
            two_stop_q <= 1'b0;
            odd_q      <= 1'b0;
            tx_line_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shadow_q   <= shadow_d;
            two_stop_q <= two_stop_d;
            odd_q      <= odd_d;
            tx_line_q  <= tx_line_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_ready = tx_ready_s;
    assign tx_line  = tx_line_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: a frame-level model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed frame samples and lengths.
module tb_uart_tx_sequencer;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset, tx_en, two_stop, odd_parity, tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, tx_line, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state: one frame at a time, described as a list of bit levels.
    bit   chk_en = 1'b0;
    bit   m_active = 1'b0;
    int   m_start, m_end;
    logic m_bits [12];
    int   acc_cnt = 0;

    // Observed frames, for the literal checks.
    int         frame_cnt = 0;
    int         fstart [16];
    int         fdone  [16];
    int         dcount [16];
    logic [11:0] samp  [16];
    bit         prev_busy = 1'b0;

    logic e_line, e_busy, e_done, e_ready;
    int   ones, off;

    uart_tx_sequencer #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .tx_en(tx_en), .two_stop(two_stop),
        .odd_parity(odd_parity), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_line(tx_line), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Per-cycle model compare plus frame monitor, on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            if (m_active && cyc < m_end) begin
                e_line = m_bits[(cyc - m_start) / CPB];
                e_busy = 1'b1; e_done = 1'b0; e_ready = 1'b0;
            end else begin
                e_line = 1'b1; e_busy = 1'b0;
                e_done = m_active && (cyc == m_end);
                e_ready = tx_en;
            end
            chk("model_tx_line", int'(tx_line), int'(e_line));
            chk("model_busy", int'(busy), int'(e_busy));
            chk("model_done", int'(done), int'(e_done));
            chk("model_tx_ready", int'(tx_ready), int'(e_ready));

            if (busy && !prev_busy && frame_cnt < 15) begin
                frame_cnt++;
                fstart[frame_cnt] = cyc;
            end
            if (busy) begin
                off = cyc - fstart[frame_cnt];
                if (off >= 0 && off % CPB == CPB / 2 && off / CPB < 12)
                    samp[frame_cnt][off / CPB] = tx_line;
            end
            if (done) begin
                fdone[frame_cnt] = cyc;
                dcount[frame_cnt]++;
            end
            prev_busy = busy;
        end

        if (reset) begin
            m_active = 1'b0;
            chk_en = 1'b1;
        end else begin
            if (m_active && cyc == m_end) m_active = 1'b0;
            if (chk_en && !m_active && tx_en && tx_valid) begin
                ones = 0;
                m_bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    m_bits[1 + i] = tx_data[i];
                    if (tx_data[i]) ones++;
                end
                m_bits[9]  = odd_parity ? logic'(1 - ones % 2) : logic'(ones % 2);
                m_bits[10] = 1'b1;
                m_bits[11] = 1'b1;
                m_start  = cyc + 1;
                m_end    = m_start + (two_stop ? 12 : 11) * CPB;
                m_active = 1'b1;
                acc_cnt++;
            end
        end
        cyc++;
    end

    task automatic send(input logic [7:0] d, input bit keep);
        int start;
        start = acc_cnt;
        tx_data = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 200 && acc_cnt == start; i++) begin
            @(posedge clk); #1;
        end
        if (acc_cnt == start) chk("accept_timeout", 0, 1);
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && m_active; i++) begin
            @(posedge clk); #1;
        end
        if (m_active) chk("idle_timeout", 0, 1);
    endtask

    task automatic chk_frame(input string name, input int f, input logic [11:0] exp, input int n);
        for (int k = 0; k < n; k++)
            chk(name, int'(samp[f][k]), int'(exp[k]));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            fstart[i] = -1; fdone[i] = -1; dcount[i] = 0; samp[i] = 12'h000;
        end
        reset = 1'b1; tx_en = 1'b0; two_stop = 1'b0; odd_parity = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_line", int'(tx_line), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(tx_ready), 0);
        tx_en = 1'b1;
        #1 chk("ready_follows_en", int'(tx_ready), 1);

        // Basic frame: 0xA5, even parity, one stop bit.
        send(8'hA5, 1'b0);
        wait_idle();
        chk_frame("basic_bits", 1, 12'b0_1_0_10100101_0, 11);
        chk("basic_len", fdone[1] - fstart[1], 44);

        // Odd parity, two stop bits.
        two_stop = 1'b1; odd_parity = 1'b1;
        send(8'hA5, 1'b0);
        wait_idle();
        chk_frame("odd2_bits", 2, 12'b1_1_1_10100101_0, 12);
        chk("odd2_len", fdone[2] - fstart[2], 48);
        chk("odd2_done_pulses", dcount[2], 1);

        // Back-to-back with tx_valid held.
        two_stop = 1'b0; odd_parity = 1'b0;
        send(8'h00, 1'b1);
        send(8'hFF, 1'b0);
        wait_idle();
        chk_frame("b2b_first", 3, 12'b0_1_0_00000000_0, 11);
        chk_frame("b2b_second", 4, 12'b0_1_0_11111111_0, 11);
        chk("b2b_spacing", fstart[4] - fstart[3], 45);
        chk("b2b_after_done", fstart[4] - fdone[3], 1);

        // Config flipped during DATA: current frame keeps captured config.
        send(8'h3C, 1'b0);
        repeat (15) @(posedge clk);
        #1 two_stop = 1'b1; odd_parity = 1'b1;
        wait_idle();
        chk_frame("cfg_old", 5, 12'b0_1_0_00111100_0, 11);
        chk("cfg_old_len", fdone[5] - fstart[5], 44);
        send(8'h3C, 1'b0);
        wait_idle();
        chk_frame("cfg_new", 6, 12'b1_1_1_00111100_0, 12);
        chk("cfg_new_len", fdone[6] - fstart[6], 48);

        // Transmitter disabled with data pending, then disabled mid-frame.
        two_stop = 1'b0; odd_parity = 1'b0;
        tx_en = 1'b0; tx_data = 8'h55; tx_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("dis_ready", int'(tx_ready), 0);
        chk("dis_line", int'(tx_line), 1);
        chk("dis_frames", frame_cnt, 6);
        tx_en = 1'b1;
        send(8'h55, 1'b0);
        repeat (10) @(posedge clk);
        #1 tx_en = 1'b0; tx_data = 8'h81; tx_valid = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk("en_off_frames", frame_cnt, 7);
        chk_frame("en_off_bits", 7, 12'b0_1_0_01010101_0, 11);
        chk("en_off_len", fdone[7] - fstart[7], 44);
        tx_en = 1'b1;
        send(8'h81, 1'b0);
        wait_idle();
        chk_frame("reen_bits", 8, 12'b0_1_0_10000001_0, 11);

        // Reset during DATA bit 3, then a clean frame.
        send(8'h0F, 1'b0);
        repeat (17) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_line", int'(tx_line), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        send(8'h96, 1'b0);
        wait_idle();
        chk("aborted_no_done", dcount[9], 0);
        chk_frame("post_rst_bits", 10, 12'b0_1_0_10010110_0, 11);
        chk("post_rst_len", fdone[10] - fstart[10], 44);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
